axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter SRAM_ADDR_BITS, default 14: SRAM word-address width (16K x 32-bit).
REQ-002 ACLK  in  1  sole clock, all state updates on rising edge.
REQ-003 ARESETn  in  1  reset, asynchronous assert, active-low.
REQ-004 AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  `AXI_IDS_BITS/32/4/3/2/1  write-address channel from interconnect.
REQ-005 AWREADY  out  1  write-address accept.
REQ-006 WDATA/WSTRB/WLAST/WVALID  in  32/4/1/1  write-data channel; WREADY  out  1.
REQ-007 BID/BRESP/BVALID  out  `AXI_IDS_BITS/2/1  write response; BREADY  in  1.
REQ-008 ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  `AXI_IDS_BITS/32/4/3/2/1  read-address channel; ARREADY  out  1.
REQ-009 RID/RDATA/RRESP/RLAST/RVALID  out  `AXI_IDS_BITS/32/2/1/1  read-data channel; RREADY  in  1.
REQ-010 SRAM_CS  out  1  chip select, active-high.
REQ-011 SRAM_OE  out  1  output enable, active-high.
REQ-012 SRAM_WEB  out  4  per-byte write enable, active-low.
REQ-013 SRAM_A  out  SRAM_ADDR_BITS  word address = byte address [SRAM_ADDR_BITS+1:2].
REQ-014 SRAM_DI  out  32  write data; SRAM_DO  in  32  read data, valid the cycle after the address edge.

Function
REQ-015 FSM states: IDLE, READ, WRITE, RESP; one transaction at a time (SASD).
REQ-016 IDLE: AWREADY=1; ARREADY=~AWVALID (write wins simultaneous AW/AR).
REQ-017 AW handshake: latch AWID, word address, AWLEN; go WRITE next cycle.
REQ-018 AR handshake: latch ARID, ARLEN, beat counter=0; SRAM_A=ARADDR word, CS=OE=1 same cycle; go READ.
REQ-019 READ: RVALID=1 from the cycle after AR handshake (latency 1), RDATA=SRAM_DO, RID=latched ID, RRESP=2'b00.
REQ-020 READ: on R handshake increment word address and beat counter; SRAM_A presents next address in the handshake cycle so next beat is ready with no bubble.
REQ-021 READ: while RVALID && !RREADY, SRAM_A holds current beat address; RDATA stable.
REQ-022 RLAST=1 iff beat counter == latched LEN; RLAST handshake returns to IDLE.
REQ-023 WRITE: WREADY=1; on W handshake SRAM_WEB=~WSTRB, SRAM_DI=WDATA, SRAM_A=current word address, CS=1; else WEB=4'hF.
REQ-024 WRITE: address increments per W handshake; WLAST handshake ends burst regardless of beat count, go RESP.
REQ-025 RESP: BVALID=1, BID=latched ID, BRESP=2'b00; hold until BREADY; B handshake -> IDLE.
REQ-026 Burst type ignored, INCR assumed; SIZE ignored, 4-byte beats assumed.
REQ-027 Word address wraps modulo 2^SRAM_ADDR_BITS; no error response.
REQ-028 Outside READ/WRITE accesses: CS=OE=0, WEB=4'hF.
REQ-029 No channel VALID output depends combinationally on its own READY input.

Reset
REQ-030 ARESETn low: state=IDLE, counters/latched ID/address=0 immediately.
REQ-031 Reset values: RVALID=BVALID=WREADY=0, RLAST=0, RDATA=0, RID=BID=0, RRESP=BRESP=0, CS=OE=0, WEB=4'hF, A=0.
REQ-032 Reset mid-burst abandons the transaction; no further beats or response after release.

Structure
REQ-033 RESP_OKAY and BURST_INCR constants live in axi_pkg; widths from AXI_define.svh.
REQ-034 FSM state enum is local to the module.
REQ-035 Single flat module; no sub-module; SRAM macro instantiated outside.

Verification
REQ-036 AR ID=8'h12 ADDR=0x100 LEN=3, RREADY=1 -> 4 beats words 0x40..0x43, RLAST on 4th, RID=8'h12.
REQ-037 Same read, RREADY low 3 cycles on beat 2 -> RDATA beat 2 held, no skipped/duplicated word.
REQ-038 AW ADDR=0x200 LEN=1, W 0xDEADBEEF strb 4'hF, 0x0000AA00 strb 4'b0010 -> WEB 4'h0 then 4'b1101, A 0x80/0x81, then BVALID, BRESP=0.
REQ-039 AWVALID and ARVALID same cycle in IDLE -> AWREADY=1, ARREADY=0; read accepted after B handshake.
REQ-040 ARESETn low during beat 2 of LEN=7 read -> RVALID=0 immediately, IDLE after release, new read works.
REQ-041 AR ADDR=0xFFFC LEN=1 -> A 0x3FFF then 0x0000.

Source files
------------

// File: rtl/axi_pkg.sv
// Common AXI constants shared by the SRAM slave and its testbench.
//   RESP_OKAY   : normal-completion response code
//   BURST_INCR  : incrementing burst encoding (the only kind the slave implements)
//   AXI_ID_BITS : transaction ID width, taken from AXI_define.svh
`include "AXI_define.svh"

package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam int         AXI_ID_BITS = `AXI_IDS_BITS;

endpackage

// File: rtl/AXI_define.svh
// Shared AXI width macros for the SRAM slave and anything that talks to it.
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH

`define AXI_IDS_BITS  8
`define AXI_ADDR_BITS 32
`define AXI_DATA_BITS 32
`define AXI_LEN_BITS  4
`define AXI_SIZE_BITS 3
`define AXI_STRB_BITS 4

`endif

// File: rtl/axi_sram_slave.sv
// AXI3 slave bridging one transaction at a time onto a synchronous 32-bit SRAM.
//
// Ports
//   ACLK, ARESETn                : clock, asynchronous active-low reset
//   AW* / AWREADY                : write-address channel
//   W*  / WREADY                 : write-data channel
//   B*  / BREADY                 : write-response channel
//   AR* / ARREADY                : read-address channel
//   R*  / RREADY                 : read-data channel
//   SRAM_CS, SRAM_OE             : chip select / output enable (active-high)
//   SRAM_WEB                     : per-byte write enable (active-low)
//   SRAM_A                       : word address
//   SRAM_DI / SRAM_DO            : write data / read data (DO valid one cycle after A)
//
// Bursts are always treated as INCR with 4-byte beats; the word address wraps
// at the SRAM size. Write always beats read when both address channels are
// valid in the same idle cycle.
`include "AXI_define.svh"

module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int SRAM_ADDR_BITS = 14
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  // write address
  input  logic [`AXI_IDS_BITS-1:0]  AWID,
  input  logic [31:0]               AWADDR,
  input  logic [3:0]                AWLEN,
  input  logic [2:0]                AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  // write data
  input  logic [31:0]               WDATA,
  input  logic [3:0]                WSTRB,
  input  logic                      WLAST,
  input  logic                      WVALID,
  output logic                      WREADY,
  // write response
  output logic [`AXI_IDS_BITS-1:0]  BID,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  // read address
  input  logic [`AXI_IDS_BITS-1:0]  ARID,
  input  logic [31:0]               ARADDR,
  input  logic [3:0]                ARLEN,
  input  logic [2:0]                ARSIZE,
  input  logic [1:0]                ARBURST,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  // read data
  output logic [`AXI_IDS_BITS-1:0]  RID,
  output logic [31:0]               RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY,
  // SRAM macro
  output logic                      SRAM_CS,
  output logic                      SRAM_OE,
  output logic [3:0]                SRAM_WEB,
  output logic [SRAM_ADDR_BITS-1:0] SRAM_A,
  output logic [31:0]               SRAM_DI,
  input  logic [31:0]               SRAM_DO
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t                      state_reg, state_next;
  logic [`AXI_IDS_BITS-1:0]    id_reg, id_next;
  logic [SRAM_ADDR_BITS-1:0]   addr_reg, addr_next;
  logic [3:0]                  len_reg, len_next;
  logic [3:0]                  beat_reg, beat_next;

  logic [SRAM_ADDR_BITS-1:0]   aw_word;
  logic [SRAM_ADDR_BITS-1:0]   ar_word;
  logic [SRAM_ADDR_BITS-1:0]   addr_inc;

  assign aw_word  = AWADDR[SRAM_ADDR_BITS+1:2];
  assign ar_word  = ARADDR[SRAM_ADDR_BITS+1:2];
  // Natural overflow gives the modulo-SRAM-size wrap.
  assign addr_inc = addr_reg + SRAM_ADDR_BITS'(1);

  // Size, burst type and the address bits outside the SRAM window carry no
  // meaning for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{AWSIZE, AWBURST, ARSIZE, ARBURST,
                           AWADDR[31:SRAM_ADDR_BITS+2], AWADDR[1:0],
                           ARADDR[31:SRAM_ADDR_BITS+2], ARADDR[1:0]};

  assign RID   = id_reg;
  assign BID   = id_reg;
  assign RRESP = RESP_OKAY;
  assign BRESP = RESP_OKAY;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg <= IDLE;
      id_reg    <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
      addr_reg  <= addr_next;
      len_reg   <= len_next;
      beat_reg  <= beat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    beat_next  = beat_reg;

    AWREADY    = 1'b0;
    ARREADY    = 1'b0;
    WREADY     = 1'b0;
    BVALID     = 1'b0;
    RVALID     = 1'b0;
    RLAST      = 1'b0;
    RDATA      = '0;
    SRAM_CS    = 1'b0;
    SRAM_OE    = 1'b0;
    SRAM_WEB   = 4'hF;
    SRAM_A     = addr_reg;
    SRAM_DI    = '0;

    unique case (state_reg)
      IDLE: begin
        AWREADY = 1'b1;
        ARREADY = ~AWVALID;
        if (AWVALID) begin
          id_next    = AWID;
          addr_next  = aw_word;
          len_next   = AWLEN;
          beat_next  = '0;
          state_next = WRITE;
        end else if (ARVALID) begin
          // Launch the first SRAM read in the handshake cycle so the data is
          // on SRAM_DO exactly when RVALID rises.
          id_next    = ARID;
          addr_next  = ar_word;
          len_next   = ARLEN;
          beat_next  = '0;
          SRAM_A     = ar_word;
          SRAM_CS    = 1'b1;
          SRAM_OE    = 1'b1;
          state_next = READ;
        end
      end

      READ: begin
        RVALID  = 1'b1;
        RDATA   = SRAM_DO;
        RLAST   = (beat_reg == len_reg);
        SRAM_CS = 1'b1;
        SRAM_OE = 1'b1;
        // When stalled the current address is re-read every cycle, which keeps
        // RDATA stable; on a handshake the next word is fetched immediately.
        if (RREADY) begin
          SRAM_A    = addr_inc;
          addr_next = addr_inc;
          beat_next = beat_reg + 4'd1;
          if (beat_reg == len_reg) begin
            state_next = IDLE;
          end
        end
      end

      WRITE: begin
        WREADY = 1'b1;
        if (WVALID) begin
          SRAM_CS   = 1'b1;
          SRAM_WEB  = ~WSTRB;
          SRAM_DI   = WDATA;
          addr_next = addr_inc;
          beat_next = beat_reg + 4'd1;
          // WLAST alone terminates the burst, whatever AWLEN promised.
          if (WLAST) begin
            state_next = RESP;
          end
        end
      end

      RESP: begin
        BVALID = 1'b1;
        if (BREADY) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam int AW  = 14;
  localparam int IDW = AXI_ID_BITS;

  logic           ACLK;
  logic           ARESETn;
  logic [IDW-1:0] AWID;
  logic [31:0]    AWADDR;
  logic [3:0]     AWLEN;
  logic [2:0]     AWSIZE;
  logic [1:0]     AWBURST;
  logic           AWVALID;
  logic           AWREADY;
  logic [31:0]    WDATA;
  logic [3:0]     WSTRB;
  logic           WLAST;
  logic           WVALID;
  logic           WREADY;
  logic [IDW-1:0] BID;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY;
  logic [IDW-1:0] ARID;
  logic [31:0]    ARADDR;
  logic [3:0]     ARLEN;
  logic [2:0]     ARSIZE;
  logic [1:0]     ARBURST;
  logic           ARVALID;
  logic           ARREADY;
  logic [IDW-1:0] RID;
  logic [31:0]    RDATA;
  logic [1:0]     RRESP;
  logic           RLAST;
  logic           RVALID;
  logic           RREADY;
  logic           SRAM_CS;
  logic           SRAM_OE;
  logic [3:0]     SRAM_WEB;
  logic [AW-1:0]  SRAM_A;
  logic [31:0]    SRAM_DI;
  logic [31:0]    SRAM_DO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    data;
    logic           last;
  } rbeat_t;

  rbeat_t         r_q[$];
  logic [IDW-1:0] b_q[$];

  logic [31:0] wd [0:7];
  logic [3:0]  ws [0:7];

  axi_sram_slave #(.SRAM_ADDR_BITS(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY),
    .SRAM_CS(SRAM_CS), .SRAM_OE(SRAM_OE), .SRAM_WEB(SRAM_WEB), .SRAM_A(SRAM_A),
    .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Background contents of every never-written word.
  function automatic logic [31:0] pattern(input logic [AW-1:0] a);
    return {2'b10, a, 2'b01, ~a};
  endfunction

  // SRAM behavioural model: registered read, byte-masked write.
  bit [31:0]   sram_mem [0:(1<<AW)-1];
  bit          sram_wr  [0:(1<<AW)-1];
  logic [31:0] sram_do_reg;
  assign SRAM_DO = sram_do_reg;

  always @(posedge ACLK) begin
    if (SRAM_CS) begin
      if (SRAM_OE) begin
        sram_do_reg <= sram_wr[SRAM_A] ? sram_mem[SRAM_A] : pattern(SRAM_A);
      end
      if (SRAM_WEB != 4'hF) begin
        for (int k = 0; k < 4; k++) begin
          if (!SRAM_WEB[k]) begin
            sram_mem[SRAM_A][8*k +: 8] <= SRAM_DI[8*k +: 8];
          end else if (!sram_wr[SRAM_A]) begin
            sram_mem[SRAM_A][8*k +: 8] <= pattern(SRAM_A) >> (8*k);
          end
        end
        sram_wr[SRAM_A] <= 1'b1;
      end
    end
  end

  // Reference memory holding what each word must read back as.
  bit [31:0] ref_mem [0:(1<<AW)-1];
  bit        ref_wr  [0:(1<<AW)-1];

  function automatic logic [31:0] ref_word(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : pattern(a);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic push_read_exp(input logic [IDW-1:0] id, input logic [31:0] addr,
                               input logic [3:0] len);
    rbeat_t e;
    logic [AW-1:0] a;
    a = addr[AW+1:2];
    for (int i = 0; i <= int'(len); i++) begin
      e.id   = id;
      e.data = ref_word(a);
      e.last = (i == int'(len));
      r_q.push_back(e);
      a = a + AW'(1);
    end
  endtask

  task automatic issue_read(input logic [IDW-1:0] id, input logic [31:0] addr,
                            input logic [3:0] len);
    int t;
    push_read_exp(id, addr, len);
    @(negedge ACLK);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = BURST_INCR;
    ARVALID = 1'b1;
    #1;
    t = 0;
    while (ARREADY !== 1'b1 && t < 50) begin
      @(negedge ACLK); #1; t++;
    end
    checks++;
    if (ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL ar_handshake: arready=%b after %0d cycles, required 1", ARREADY, t);
    end
    checks++;
    if (SRAM_A !== addr[AW+1:2] || SRAM_CS !== 1'b1 || SRAM_OE !== 1'b1) begin
      errors++;
      $display("FAIL ar_sram: A=%h cs=%b oe=%b, required A=%h cs=1 oe=1",
               SRAM_A, SRAM_CS, SRAM_OE, addr[AW+1:2]);
    end
    $display("AR id=%h addr=%h len=%0d", id, addr, len);
    @(posedge ACLK);
  endtask

  // Drains one read burst from the scoreboard; optionally stalls RREADY.
  task automatic drain_read(input logic [AW-1:0] base, input logic [3:0] len,
                            input int stall_beat, input int stall_cycles);
    int beat = 0;
    int stalled = 0;
    int guard = 0;
    logic [AW-1:0] exp_a;
    rbeat_t e;
    while (beat <= int'(len) && guard < 100) begin
      @(negedge ACLK);
      ARVALID = 1'b0;
      RREADY = !(beat == stall_beat && stalled < stall_cycles);
      #1;
      if (guard == 0) begin
        checks++;
        if (RVALID !== 1'b1) begin
          errors++;
          $display("FAIL r_latency: rvalid=%b one cycle after AR, required 1", RVALID);
        end
      end
      if (RVALID === 1'b1 && r_q.size() > 0) begin
        e = r_q[0];
        checks++;
        if (RDATA !== e.data || RID !== e.id || RLAST !== e.last || RRESP !== RESP_OKAY) begin
          errors++;
          $display("FAIL r_beat%0d: data=%h id=%h last=%b resp=%b, required data=%h id=%h last=%b resp=00",
                   beat, RDATA, RID, RLAST, RRESP, e.data, e.id, e.last);
        end
        exp_a = base + AW'(beat) + (RREADY ? AW'(1) : AW'(0));
        checks++;
        if (SRAM_A !== exp_a || SRAM_CS !== 1'b1 || SRAM_OE !== 1'b1) begin
          errors++;
          $display("FAIL r_addr%0d: A=%h cs=%b oe=%b, required A=%h cs=1 oe=1",
                   beat, SRAM_A, SRAM_CS, SRAM_OE, exp_a);
        end
        if (RREADY) begin
          $display("R  id=%h data=%h last=%b", RID, RDATA, RLAST);
          void'(r_q.pop_front());
          beat++;
        end else begin
          stalled++;
        end
      end
      guard++;
    end
    if (beat <= int'(len)) begin
      checks++;
      errors++;
      $display("FAIL r_timeout: got %0d beats, required %0d", beat, int'(len) + 1);
    end
    @(negedge ACLK);
    RREADY = 1'b0;
    #1;
    checks++;
    if (RVALID !== 1'b0) begin
      errors++;
      $display("FAIL r_after_last: rvalid=%b, required 0", RVALID);
    end
  endtask

  task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input int n);
    int t;
    logic [AW-1:0] a;
    b_q.push_back(id);
    @(negedge ACLK);
    AWID = id; AWADDR = addr; AWLEN = 4'(n - 1); AWSIZE = 3'd2; AWBURST = BURST_INCR;
    AWVALID = 1'b1;
    #1;
    t = 0;
    while (AWREADY !== 1'b1 && t < 50) begin
      @(negedge ACLK); #1; t++;
    end
    checks++;
    if (AWREADY !== 1'b1) begin
      errors++;
      $display("FAIL aw_handshake: awready=%b, required 1", AWREADY);
    end
    $display("AW id=%h addr=%h len=%0d", id, addr, n - 1);
    @(posedge ACLK);
    a = addr[AW+1:2];
    for (int b = 0; b < n; b++) begin
      @(negedge ACLK);
      AWVALID = 1'b0;
      WDATA = wd[b]; WSTRB = ws[b]; WLAST = (b == n - 1); WVALID = 1'b1;
      #1;
      checks++;
      if (WREADY !== 1'b1 || SRAM_WEB !== ~ws[b] || SRAM_A !== a || SRAM_CS !== 1'b1 ||
          SRAM_OE !== 1'b0 || SRAM_DI !== wd[b]) begin
        errors++;
        $display("FAIL w_beat%0d: wready=%b web=%b A=%h cs=%b oe=%b di=%h, required wready=1 web=%b A=%h cs=1 oe=0 di=%h",
                 b, WREADY, SRAM_WEB, SRAM_A, SRAM_CS, SRAM_OE, SRAM_DI, ~ws[b], a, wd[b]);
      end
      ref_mem[a] = ref_word(a);
      for (int k = 0; k < 4; k++) begin
        if (ws[b][k]) ref_mem[a][8*k +: 8] = wd[b][8*k +: 8];
      end
      ref_wr[a] = 1'b1;
      $display("W  data=%h strb=%b last=%b", wd[b], ws[b], WLAST);
      @(posedge ACLK);
      a = a + AW'(1);
    end
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
    #1;
    checks++;
    if (SRAM_WEB !== 4'hF || SRAM_CS !== 1'b0 || WREADY !== 1'b0) begin
      errors++;
      $display("FAIL w_done: web=%b cs=%b wready=%b, required web=1111 cs=0 wready=0",
               SRAM_WEB, SRAM_CS, WREADY);
    end
    t = 0;
    while (BVALID !== 1'b1 && t < 50) begin
      @(negedge ACLK); #1; t++;
    end
    checks++;
    if (BVALID !== 1'b1 || BID !== b_q[0] || BRESP !== RESP_OKAY) begin
      errors++;
      $display("FAIL b_resp: bvalid=%b bid=%h bresp=%b, required bvalid=1 bid=%h bresp=00",
               BVALID, BID, BRESP, b_q[0]);
    end
    @(negedge ACLK);
    #1;
    checks++;
    if (BVALID !== 1'b1) begin
      errors++;
      $display("FAIL b_hold: bvalid=%b while bready low, required 1", BVALID);
    end
    BREADY = 1'b1;
    $display("B  id=%h resp=%b", BID, BRESP);
    void'(b_q.pop_front());
    @(posedge ACLK);
    @(negedge ACLK);
    BREADY = 1'b0;
    #1;
    checks++;
    if (BVALID !== 1'b0) begin
      errors++;
      $display("FAIL b_release: bvalid=%b after handshake, required 0", BVALID);
    end
  endtask

  task automatic test_reset;
    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    #1;
    checks++;
    if (RVALID !== 1'b0 || BVALID !== 1'b0 || WREADY !== 1'b0 || RLAST !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: rvalid=%b bvalid=%b wready=%b rlast=%b, required all 0",
               RVALID, BVALID, WREADY, RLAST);
    end
    checks++;
    if (RDATA !== 32'h0 || RID !== '0 || BID !== '0 || RRESP !== 2'b00 || BRESP !== 2'b00) begin
      errors++;
      $display("FAIL reset_data: rdata=%h rid=%h bid=%h rresp=%b bresp=%b, required all 0",
               RDATA, RID, BID, RRESP, BRESP);
    end
    checks++;
    if (SRAM_CS !== 1'b0 || SRAM_OE !== 1'b0 || SRAM_WEB !== 4'hF || SRAM_A !== '0) begin
      errors++;
      $display("FAIL reset_sram: cs=%b oe=%b web=%b A=%h, required cs=0 oe=0 web=1111 A=0",
               SRAM_CS, SRAM_OE, SRAM_WEB, SRAM_A);
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
    #1;
    checks++;
    if (AWREADY !== 1'b1 || ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: awready=%b arready=%b rvalid=%b, required 1 1 0",
               AWREADY, ARREADY, RVALID);
    end
  endtask

  task automatic test_read_burst;
    issue_read(8'h12, 32'h100, 4'd3);
    drain_read(14'h40, 4'd3, -1, 0);
  endtask

  task automatic test_read_stall;
    issue_read(8'h12, 32'h100, 4'd3);
    drain_read(14'h40, 4'd3, 1, 3);
  endtask

  task automatic test_write;
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    wd[1] = 32'h0000AA00; ws[1] = 4'b0010;
    do_write(8'h21, 32'h200, 2);
    issue_read(8'h22, 32'h200, 4'd1);
    drain_read(14'h80, 4'd1, -1, 0);
  endtask

  task automatic test_priority;
    @(negedge ACLK);
    AWID = 8'h34; AWADDR = 32'h300; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = BURST_INCR;
    AWVALID = 1'b1;
    ARID = 8'h56; ARADDR = 32'h400; ARLEN = 4'd1; ARSIZE = 3'd2; ARBURST = BURST_INCR;
    ARVALID = 1'b1;
    #1;
    checks++;
    if (AWREADY !== 1'b1 || ARREADY !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle: awready=%b arready=%b, required 1 0", AWREADY, ARREADY);
    end
    $display("AW id=%h addr=%h len=0 (with AR pending)", AWID, AWADDR);
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 1'b0;
    WDATA = 32'h13572468; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    #1;
    checks++;
    if (WREADY !== 1'b1 || ARREADY !== 1'b0 || SRAM_A !== 14'hC0) begin
      errors++;
      $display("FAIL prio_write: wready=%b arready=%b A=%h, required 1 0 0c0",
               WREADY, ARREADY, SRAM_A);
    end
    ref_mem[14'hC0] = 32'h13572468;
    ref_wr[14'hC0]  = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
    #1;
    checks++;
    if (BVALID !== 1'b1 || BID !== 8'h34 || ARREADY !== 1'b0) begin
      errors++;
      $display("FAIL prio_resp: bvalid=%b bid=%h arready=%b, required 1 34 0",
               BVALID, BID, ARREADY);
    end
    BREADY = 1'b1;
    $display("B  id=%h resp=%b", BID, BRESP);
    @(posedge ACLK);
    @(negedge ACLK);
    BREADY = 1'b0;
    #1;
    checks++;
    if (ARREADY !== 1'b1 || SRAM_A !== 14'h100 || SRAM_CS !== 1'b1 || SRAM_OE !== 1'b1) begin
      errors++;
      $display("FAIL prio_read_accept: arready=%b A=%h cs=%b oe=%b, required 1 100 1 1",
               ARREADY, SRAM_A, SRAM_CS, SRAM_OE);
    end
    push_read_exp(8'h56, 32'h400, 4'd1);
    $display("AR id=56 addr=00000400 len=1 (after B)");
    @(posedge ACLK);
    drain_read(14'h100, 4'd1, -1, 0);
    issue_read(8'h57, 32'h300, 4'd0);
    drain_read(14'hC0, 4'd0, -1, 0);
  endtask

  task automatic test_reset_mid;
    rbeat_t e;
    issue_read(8'h77, 32'h1000, 4'd7);
    @(negedge ACLK);
    ARVALID = 1'b0;
    RREADY = 1'b1;
    #1;
    e = r_q[0];
    checks++;
    if (RVALID !== 1'b1 || RDATA !== e.data || RID !== e.id) begin
      errors++;
      $display("FAIL rst_beat1: rvalid=%b data=%h id=%h, required 1 %h %h",
               RVALID, RDATA, RID, e.data, e.id);
    end
    $display("R  id=%h data=%h last=%b", RID, RDATA, RLAST);
    @(posedge ACLK);
    @(negedge ACLK);
    RREADY = 1'b0;
    #1;
    checks++;
    if (RVALID !== 1'b1) begin
      errors++;
      $display("FAIL rst_beat2: rvalid=%b before reset, required 1", RVALID);
    end
    ARESETn = 1'b0;
    #1;
    checks++;
    if (RVALID !== 1'b0 || RLAST !== 1'b0 || RDATA !== 32'h0 || SRAM_CS !== 1'b0 ||
        SRAM_WEB !== 4'hF || SRAM_A !== '0 || RID !== '0) begin
      errors++;
      $display("FAIL rst_async: rvalid=%b rlast=%b rdata=%h cs=%b web=%b A=%h rid=%h, required 0 0 0 0 1111 0 0",
               RVALID, RLAST, RDATA, SRAM_CS, SRAM_WEB, SRAM_A, RID);
    end
    $display("RST asserted mid-burst");
    r_q.delete();
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      RREADY = 1'b1;
      #1;
      checks++;
      if (RVALID !== 1'b0 || BVALID !== 1'b0 || ARREADY !== 1'b1) begin
        errors++;
        $display("FAIL rst_abandon%0d: rvalid=%b bvalid=%b arready=%b, required 0 0 1",
                 i, RVALID, BVALID, ARREADY);
      end
    end
    RREADY = 1'b0;
    issue_read(8'h78, 32'h2004, 4'd2);
    drain_read(14'h801, 4'd2, 0, 1);
  endtask

  task automatic test_wrap;
    issue_read(8'h99, 32'hFFFC, 4'd1);
    drain_read(14'h3FFF, 4'd1, -1, 0);
  endtask

  initial begin
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;

    test_reset();
    test_read_burst();
    test_read_stall();
    test_write();
    test_priority();
    test_reset_mid();
    test_wrap();

    repeat (2) @(negedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
